// File: rtl/pdm_cic_decimator.sv
// PDM microphone front end: generates MIC_CLK, captures MIC_DAT on the falling
// MIC_CLK edge, runs a 3rd-order CIC decimator and hands 16-bit PCM samples to
// the SPI readout stage through a one-deep valid/ready holding register.
//
// Ports:
//   CLK_MCO      master clock, clocks every register
//   RST          asynchronous active-high reset
//   EN           enable; low holds the block idle and cleared
//   MIC_DAT      PDM data from the microphone
//   MIC_CLK      PDM bit clock, 50% duty, period 2*CLK_DIV
//   SAMPLE       signed 16-bit PCM sample
//   SAMPLE_VALID SAMPLE holds an unconsumed sample
//   SAMPLE_READY consumer accepts SAMPLE when VALID and READY are high
//   OVERRUN      sticky, a sample was overwritten before acceptance
//   OVR_CLR      synchronous clear of OVERRUN
module pdm_cic_decimator #(
    parameter int CLK_DIV = 2,
    parameter int DECIM   = 64,
    parameter int OUT_W   = 16
) (
    input  logic             CLK_MCO,
    input  logic             RST,
    input  logic             EN,
    input  logic             MIC_DAT,
    output logic             MIC_CLK,
    output logic [OUT_W-1:0] SAMPLE,
    output logic             SAMPLE_VALID,
    input  logic             SAMPLE_READY,
    output logic             OVERRUN,
    input  logic             OVR_CLR
);

    localparam int LOG2D = $clog2(DECIM);
    localparam int W     = 3 * LOG2D + 1;
    localparam int SHIFT = W - OUT_W;

    localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [LOG2D-1:0] BIT_LAST = LOG2D'(DECIM - 1);
    localparam logic [W-1:0]     MIN_VAL  = {1'b1, {(W-1){1'b0}}};

    // clock divider
    logic [7:0] div_cnt;
    logic       div_tc;
    logic       cap;

    assign div_tc = (div_cnt == DIV_LAST);
    assign cap    = div_tc && MIC_CLK;

    always_ff @(posedge CLK_MCO or posedge RST) begin
        if (RST) begin
            div_cnt <= '0;
            MIC_CLK <= 1'b0;
        end else if (!EN) begin
            div_cnt <= '0;
            MIC_CLK <= 1'b0;
        end else if (div_tc) begin
            div_cnt <= '0;
            MIC_CLK <= ~MIC_CLK;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    // capture on MIC_CLK 1->0
    logic tick;
    logic pdm_bit;

    always_ff @(posedge CLK_MCO or posedge RST) begin
        if (RST) begin
            tick    <= 1'b0;
            pdm_bit <= 1'b0;
        end else if (!EN) begin
            tick    <= 1'b0;
            pdm_bit <= 1'b0;
        end else begin
            tick <= cap;
            if (cap) begin
                pdm_bit <= MIC_DAT;
            end
        end
    end

    // integrators, wrapping modulo 2^W
    logic [W-1:0]     integ1;
    logic [W-1:0]     integ2;
    logic [W-1:0]     integ3;
    logic [W-1:0]     x;
    logic [LOG2D-1:0] bit_cnt;
    logic             comb_go;

    assign x = pdm_bit ? W'(1) : {W{1'b1}};

    always_ff @(posedge CLK_MCO or posedge RST) begin
        if (RST) begin
            integ1  <= '0;
            integ2  <= '0;
            integ3  <= '0;
            bit_cnt <= '0;
            comb_go <= 1'b0;
        end else if (!EN) begin
            integ1  <= '0;
            integ2  <= '0;
            integ3  <= '0;
            bit_cnt <= '0;
            comb_go <= 1'b0;
        end else begin
            comb_go <= tick && (bit_cnt == BIT_LAST);
            if (tick) begin
                integ1  <= integ1 + x;
                integ2  <= integ2 + integ1;
                integ3  <= integ3 + integ2;
                bit_cnt <= bit_cnt + LOG2D'(1);
            end
        end
    end

    // combs, run once per frame
    logic [W-1:0]        d1;
    logic [W-1:0]        d2;
    logic [W-1:0]        d3;
    logic [W-1:0]        c1;
    logic [W-1:0]        c2;
    logic [W-1:0]        c3;
    logic signed [W-1:0] y_q;
    logic                y_top;
    logic                out_go;

    assign c1 = integ3 - d1;
    assign c2 = c1 - d2;
    assign c3 = c2 - d3;

    // The full-scale results +2^(W-1) and -2^(W-1) alias in W bits. They
    // only occur for an all-ones or all-zeros window, so the most recent
    // PDM bit tells them apart.
    always_ff @(posedge CLK_MCO or posedge RST) begin
        if (RST) begin
            d1     <= '0;
            d2     <= '0;
            d3     <= '0;
            y_q    <= '0;
            y_top  <= 1'b0;
            out_go <= 1'b0;
        end else if (!EN) begin
            d1     <= '0;
            d2     <= '0;
            d3     <= '0;
            y_q    <= '0;
            y_top  <= 1'b0;
            out_go <= 1'b0;
        end else begin
            out_go <= comb_go;
            if (comb_go) begin
                d1    <= integ3;
                d2    <= c1;
                d3    <= c2;
                y_q   <= c3;
                y_top <= (c3 == MIN_VAL) && pdm_bit;
            end
        end
    end

    // scaling
    logic [OUT_W-1:0] scaled;

    always_comb begin
        scaled = OUT_W'(y_q >>> SHIFT);
        if (y_top) begin
            scaled = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

    // warm-up: drop the first three comb outputs
    logic [1:0] warm;
    logic       load;

    assign load = out_go && (warm == 2'd3);

    always_ff @(posedge CLK_MCO or posedge RST) begin
        if (RST) begin
            warm <= '0;
        end else if (!EN) begin
            warm <= '0;
        end else if (out_go && (warm != 2'd3)) begin
            warm <= warm + 2'd1;
        end
    end

    // holding register and handshake
    always_ff @(posedge CLK_MCO or posedge RST) begin
        if (RST) begin
            SAMPLE       <= '0;
            SAMPLE_VALID <= 1'b0;
            OVERRUN      <= 1'b0;
        end else if (!EN) begin
            SAMPLE       <= '0;
            SAMPLE_VALID <= 1'b0;
            OVERRUN      <= 1'b0;
        end else begin
            if (load) begin
                SAMPLE       <= scaled;
                SAMPLE_VALID <= 1'b1;
            end else if (SAMPLE_VALID && SAMPLE_READY) begin
                SAMPLE_VALID <= 1'b0;
            end
            // set has priority over clear
            if (load && SAMPLE_VALID && !SAMPLE_READY) begin
                OVERRUN <= 1'b1;
            end else if (OVR_CLR) begin
                OVERRUN <= 1'b0;
            end
        end
    end

endmodule
